// File: rtl/aes_pkg.sv
// Shared AES-128 decrypt types, constants and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned RND_W  = 4;

  typedef logic [BLK_W-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  // Byte idx = row + 4*col; byte 0 occupies bits 127:120.
  function automatic logic [7:0] get_byte(state_t s, logic [3:0] idx);
    return s[{~idx, 3'b111} -: 8];
  endfunction

  function automatic state_t set_byte(state_t s, logic [3:0] idx, logic [7:0] b);
    state_t o;
    o = s;
    o[{~idx, 3'b111} -: 8] = b;
    return o;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] inv_mix_column(logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
            gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
            gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
            gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
  endfunction

  // Row r rotates right by r: column c pulls its row-r byte from column (c-r) mod 4.
  function automatic state_t inv_shift_rows(state_t s);
    state_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o = set_byte(o, 4'(4 * c + r), get_byte(s, 4'(4 * ((c + 4 - r) % 4) + r)));
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_sbox.sv
// Combinational AES inverse S-box lookup.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 sits in the top byte, so the bit offset is 8 * (255 - a).
  assign y = INV_SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: whitening on accept, then one inverse round per clock.
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  fsm_t             fsm;
  logic [RND_W-1:0] rnd;
  state_t           state;

  state_t sr;
  state_t sub;
  state_t ark;
  state_t mixed;
  state_t nxt;

  assign sr = inv_shift_rows(state);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a (sr[127-8*i -: 8]),
      .y (sub[127-8*i -: 8])
    );
  end

  assign ark = sub ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
  end

  // Final round (rnd 0) skips InvMixColumns.
  assign nxt       = (rnd == '0) ? ark : mixed;
  assign plaintext = state;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fsm       <= IDLE;
      state     <= '0;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      key_idx   <= RND_W'(AES_NR);
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state    <= ciphertext ^ round_key;
            rnd      <= RND_W'(AES_NR - 1);
            key_idx  <= RND_W'(AES_NR - 1);
            in_ready <= 1'b0;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          state <= nxt;
          if (rnd == '0) begin
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            rnd     <= rnd - RND_W'(1);
            key_idx <= rnd - RND_W'(1);
          end
        end
        DONE: begin
          // Return to IDLE without accepting in the same cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            key_idx   <= RND_W'(AES_NR);
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter against a forward-AES reference model.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  logic [127:0] rk [0:10];
  logic [7:0]   sb [0:255];

  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           acc_log [$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           ready_mode = 0;
  logic         ov_prev = 1'b0;
  logic [127:0] rk_at_accept;

  aes_inv_cipher_iter dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key_idx    (key_idx),
    .round_key  (round_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  // Key store: combinational lookup of the current expansion.
  assign round_key = (key_idx <= 4'd10) ? rk[key_idx] : 128'h0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // Forward S-box from its definition: GF inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, t, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      t = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ rk[0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd != 10) begin
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      v = v ^ rk[rd];
    end
    return v;
  endfunction

  // Offer one block; push its expected plaintext when the accept edge is due.
  task automatic send(input logic [127:0] ct, input logic [127:0] exp, input bit hold);
    int waited;
    bit ok;
    waited = 0;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    ciphertext = ct;
    while (!ok && waited < 100) begin
      if (in_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    chk("key_idx_at_accept", 128'(key_idx), 128'd10);
    rk_at_accept = round_key;
    exp_q.push_back(exp);
    acc_q.push_back(cyc + 1);
    acc_log.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid = hold;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_plaintext", plaintext, 128'h0);
    chk("rst_key_idx", 128'(key_idx), 128'd10);
  endtask

  // Monitor: every cycle out_valid is high the plaintext must match the queue head.
  always @(negedge clk) begin
    if (n_rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected no output", plaintext);
      end else begin
        if (!ov_prev) chk("latency", 128'(cyc - acc_q[0]), 128'd10);
        chk("plaintext", plaintext, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
    end
    ov_prev = out_valid;
  end

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    logic [127:0] pt, key;
    n_rst = 1'b0;
    in_valid = 1'b0;
    ciphertext = '0;
    out_ready = 1'b1;
    build_sbox();
    load_key(C1_KEY);
    repeat (2) @(posedge clk);
    do_reset();

    // FIPS-197 C.1 with key_idx trace.
    send(C1_CT, C1_PT, 1'b0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("key_idx_trace", 128'(key_idx), 128'(9 - j));
    end
    wait_drain();

    // FIPS-197 Appendix B.
    load_key(B_KEY);
    send(B_CT, B_PT, 1'b0);
    chk("rk10_at_accept", rk_at_accept, B_RK10);
    wait_drain();

    // Backpressure: hold the result for 20 cycles while new input is offered.
    ready_mode = 2;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(aes_enc(pt), pt, 1'b0);
    for (int w = 0; w < 100 && !out_valid; w++) @(negedge clk);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ciphertext = {$urandom, $urandom, $urandom, $urandom};
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    ready_mode = 0;
    wait_drain();
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(aes_enc(pt), pt, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held high.
    acc_log.delete();
    for (int k = 0; k < 3; k++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(aes_enc(pt), pt, k != 2);
    end
    wait_drain();
    if (acc_log.size() == 3) begin
      chk("b2b_spacing_01", 128'(acc_log[1] - acc_log[0]), 128'd12);
      chk("b2b_spacing_12", 128'(acc_log[2] - acc_log[1]), 128'd12);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL b2b_accepts: got %0d expected 3", acc_log.size());
    end

    // Reset in the middle of a block, then a clean C.1 decrypt.
    load_key(C1_KEY);
    send(C1_CT, C1_PT, 1'b0);
    repeat (4) @(negedge clk);
    do_reset();
    send(C1_CT, C1_PT, 1'b0);
    wait_drain();

    // Random keys and blocks with random output stalls.
    ready_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      wait_drain();
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(aes_enc(pt), pt, 1'b0);
    end
    wait_drain();
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 decryption core: one ciphertext block in, one plaintext block out, one inverse round per clock. It is the decrypt-side counterpart of the encrypt datapath and applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. Round keys come from an external key store addressed by this block. It sits between the host block buffer and the output FIFO, using valid/ready on both sides.

## Interface
- No parameters. AES-128 only, Nr = 10.
- clk  in  1  single clock, rising edge
- n_rst  in  1  synchronous, active-low reset
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  core idle and able to accept
- ciphertext  in  128  block; bits 127:120 = state byte s(0,0), column-major (column c in bits 127-32c : 96-32c, row 0 most significant)
- key_idx  out  4  round-key index requested, 0..10
- round_key  in  128  round key for key_idx, valid combinationally in the same cycle, same byte layout
- out_valid  out  1  plaintext valid
- out_ready  in  1  downstream accepts plaintext
- plaintext  out  128  result, same byte layout

## Operation
- State register: 128-bit `state`, 4-bit `rnd`, FSM {IDLE, ROUND, DONE}.
- IDLE: in_ready=1, key_idx=10. On in_valid&in_ready: state <= ciphertext ^ round_key (whitening with rk10), rnd <= 9, go to ROUND.
- ROUND: key_idx = rnd.
  - rnd 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key), rnd <= rnd-1.
  - rnd 0: state <= InvSubBytes(InvShiftRows(state)) ^ round_key, go to DONE.
- InvShiftRows: row r rotated right by r byte positions, so column c takes row-r byte from column (c-r) mod 4.
- InvMixColumns: per column, GF(2^8) multiply by {0e,0b,0d,09} circulant, reduction polynomial 0x11B.
- DONE: out_valid=1, plaintext=state. On out_ready go to IDLE; in_ready stays 0 that cycle. No same-cycle accept-on-drain.
- plaintext drives `state` continuously; it is only meaningful while out_valid=1.
- in_valid during ROUND/DONE is ignored. ciphertext is sampled only on the accept edge.
- key_idx is a registered-state decode, so it is glitch-free relative to clk. round_key must not combinationally depend on in_valid.

## Timing
- Reset (n_rst=0 at a rising edge): FSM=IDLE, state=0, rnd=0. Outputs: in_ready=1, out_valid=0, plaintext=0, key_idx=10.
- Reset mid-operation aborts the block with no output. The next edge with n_rst=1 behaves as IDLE.
- Latency: the accept edge is edge 0. Rounds run on edges 1..10. out_valid is high after edge 10, i.e. 10 cycles after accept.
- Throughput: at most one block per 12 cycles (accept, 10 rounds, 1 DONE cycle with immediate out_ready), then IDLE for 1 cycle.
- Backpressure: DONE holds plaintext stable and out_valid high indefinitely until out_ready=1.
- out_ready while not in DONE has no effect.

## Structure
- Package aes_pkg holds:
  - typedef state_t (logic [127:0]) and byte accessors
  - constant AES_NR = 10
  - functions xtime, gmul for constants 9/11/13/14, inv_mix_column (32-bit), inv_shift_rows (128-bit)
- Sub-module aes_inv_sbox (8-bit in, 8-bit out, combinational 256-entry table), instantiated 16 times.
- Top level: FSM plus the round mux (final round skips InvMixColumns).

## Test plan
- FIPS-197 C.1: the bench key store returns the expansion of key 000102030405060708090a0b0c0d0e0f. Ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept; key_idx sequence 10,9,…,0.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. Check first-accept key_idx=10 and rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Plaintext stays stable, in_ready=0, a new in_valid is ignored; release → IDLE, next block decrypts correctly.
- Back-to-back: in_valid held high with 3 vectors, out_ready=1. Accepts are spaced 12 cycles apart and all results match the reference model.
- Reset at round 5: n_rst=0 for one edge → out_valid=0, in_ready=1, key_idx=10. The following C.1 block gives the correct result.
- Random: 1000 random key/ciphertext pairs against a software AES model, with random out_ready stalls. There must be zero mismatches.
